fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Decoupling instruction queue between the fetch stage and decode. It buffers
//  fetched {pc, instr, error} entries so that ibus/translation latency is
//  hidden from decode. Its in_ready drives the fetch stage's stop input.
//  A pipeline redirect (branch or trap) flushes the queue in one cycle.
// PARAMETERS
//  DEPTH  4  entries; power of two, >= 2
//  ERR_W  3  width of the error code field; 0 = NOERROR
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high reset
//  flush      in   1      redirect (flushall | branch); discards all entries
//  in_valid   in   1      fetch presents an entry
//  in_pc      in   64     pc of the entry
//  in_instr   in   32     instruction word
//  in_error   in   ERR_W  fetch error code (e.g. INSTR_MISALIGN)
//  in_ready   out  1      queue accepts an entry this cycle (fetch stop = ~in_ready)
//  out_valid  out  1      head entry valid to decode
//  out_pc     out  64     head pc
//  out_instr  out  32     head instruction
//  out_error  out  ERR_W  head error code
//  out_ready  in   1      decode consumes the head this cycle
//  count      out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: circular array of DEPTH entries. Head and tail pointers are
//    $clog2(DEPTH)+1 bits wide; the MSB is a wrap bit.
//    empty = (head == tail); full = (idx equal, wrap bits differ).
//  - enq = in_valid & in_ready: write entry at tail, then tail+1.
//  - deq = out_valid & out_ready: head+1.
//  - count is registered: +1 on enq only, -1 on deq only, unchanged on both.
//  - in_ready = ~full & ~poisoned & ~reset. There is no pass-through when full,
//    so a same-cycle deq does not free a slot for a same-cycle enq.
//  - out_valid = ~empty. out_* is read combinationally from the head entry.
//    Latency from enq to out_valid is 1 cycle.
//  - Simultaneous enq+deq on a non-full, non-empty queue: both take effect.
//    Order is preserved.
//  - Poison: enqueueing an entry with in_error != 0 sets poisoned.
//    - While poisoned, in_ready = 0. This guarantees no younger instruction
//      follows a faulting fetch.
//    - Only flush or reset clears poisoned.
//    - The faulting entry itself still drains to decode normally.
//  - flush (priority over enq and deq in the same cycle):
//    - head = tail = 0, count = 0, poisoned = 0.
//    - The same-cycle input is dropped.
//    - out_valid = 0 from the next cycle. In the flush cycle out_valid still
//      reflects the old head, but decode must ignore it.
//  - reset (priority over everything, including mid-operation):
//    - Same effects as flush.
//    - Outputs after reset: out_valid = 0, count = 0, in_ready = 1.
//      out_pc, out_instr and out_error read array slot 0; array contents are
//      not reset, and out_* is don't-care while out_valid = 0.
//  - Pointer wrap: idx wraps DEPTH-1 -> 0 and the wrap bit toggles.
//    No other special case.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN defined:
//  - When empty & in_valid & ~flush, out_* is driven combinationally from
//    in_* and out_valid = 1.
//  - If out_ready is also 1, the entry is consumed with zero latency:
//    no array write, no pointer or count change.
//  - If out_ready = 0, the entry is enqueued normally.
//  - Poison still sets on a bypassed erroring entry.
//  - flush forces out_valid = 0 in that cycle.
//  FETCH_QUEUE_BYPASS_EN undefined:
//  - No combinational in->out path.
//  - Minimum latency is 1 cycle, as described above.
// TESTING
//  1. After reset, in_valid=1 with pc=0x80000000..0x8000000C (4 entries),
//     out_ready=0 -> count=4, in_ready=0 on the cycle after the 4th enq.
//  2. From full, out_ready=1 for 4 cycles -> out_pc=0x80000000,04,08,0C in
//     order; count=0, out_valid=0 after that.
//  3. Steady stream with in_valid=out_ready=1 for 10 cycles (DEPTH=4) ->
//     pointers wrap twice, no entry lost or duplicated, count stays 1.
//  4. Entry pc=0x80000002, error=INSTR_MISALIGN enqueued, then in_valid held
//     at 1 -> in_ready=0 until flush. The error entry drains with
//     out_error=INSTR_MISALIGN.
//  5. count=3 and flush=1 together with in_valid=1 and out_ready=1 ->
//     next cycle count=0, out_valid=0, in_ready=1, input not stored.
//  6. With FETCH_QUEUE_BYPASS_EN: empty, in_valid=1, out_ready=1,
//     pc=0x80001000 -> same cycle out_valid=1, out_pc=0x80001000, count stays 0.
//     Without the macro: out_valid rises 1 cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: enq->out_valid 1 cycle (0 with FETCH_QUEUE_BYPASS_EN), flush/reset clear in one cycle.
// Backpressure: in_ready drops when full, during reset, or once an erroring entry is accepted (until flush/reset).
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [63:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic [ERR_W-1:0]         in_error,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [ERR_W-1:0]         out_error,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [ERR_W-1:0] err_mem   [DEPTH];

  logic [AW:0]   head, tail;
  logic [AW:0]   count_q;
  logic          poisoned;
  logic [AW-1:0] head_idx, tail_idx;
  logic          empty, full, enq, deq, wr_en, rd_en, byp_take;

  assign head_idx = head[AW-1:0];
  assign tail_idx = tail[AW-1:0];
  assign count    = count_q;

  always_comb begin
    empty    = (head == tail);
    full     = (head_idx == tail_idx) && (head[AW] != tail[AW]);
    in_ready = ~full & ~poisoned & ~reset;
    enq      = in_valid & in_ready;
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp_vld;
  // Gated by in_ready so a poisoned queue cannot leak a younger entry through the bypass.
  always_comb begin
    byp_vld   = empty & in_valid & in_ready & ~flush;
    out_valid = ~flush & (~empty | byp_vld);
    out_pc    = byp_vld ? in_pc    : pc_mem[head_idx];
    out_instr = byp_vld ? in_instr : instr_mem[head_idx];
    out_error = byp_vld ? in_error : err_mem[head_idx];
    byp_take  = byp_vld & out_ready;
  end
`else
  always_comb begin
    out_valid = ~empty;
    out_pc    = pc_mem[head_idx];
    out_instr = instr_mem[head_idx];
    out_error = err_mem[head_idx];
    byp_take  = 1'b0;
  end
`endif

  always_comb begin
    deq   = out_valid & out_ready;
    wr_en = enq & ~byp_take;
    rd_en = deq & ~byp_take;
  end

  // Storage is deliberately not reset; out_* is don't-care while out_valid is low.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      pc_mem[tail_idx]    <= in_pc;
      instr_mem[tail_idx] <= in_instr;
      err_mem[tail_idx]   <= in_error;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      poisoned <= 1'b0;
    end else begin
      if (wr_en) tail <= tail + 1'b1;
      if (rd_en) head <= head + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (enq && (in_error != '0)) poisoned <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, ERR_W=3); honours FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

  localparam logic [2:0] INSTR_MISALIGN = 3'd1;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic [2:0]  in_error;
  logic        in_ready, out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  out_error;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(4), .ERR_W(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_error(in_error),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_error(out_error), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [2:0] err, input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = pc[31:0] ^ 32'h0000_0013;
    in_error  = err;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 64'h0, 3'd0, 1'b0);
    tick();
    chk("rst_in_ready_low", in_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);

    // Fill to full with out_ready low.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 3'd0, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
      if (i == 0) chk("fill_byp_vld", out_valid, 1);
`else
      if (i == 0) chk("fill_lat_vld", out_valid, 0);
`endif
      tick();
    end
    drive(1'b0, 64'h0, 3'd0, 1'b0);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_head_pc", out_pc, 64'h8000_0000);

    // Drain; first cycle also offers an entry that must be refused while full.
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 64'hDEAD, 3'd0, 1'b1);
      if (i == 0) chk("full_no_passthru", in_ready, 0);
      chk("drain_vld", out_valid, 1);
      chk("drain_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
      tick();
      chk("drain_count", count, 3'(3 - i));
    end
    drive(1'b0, 64'h0, 3'd0, 1'b0);
    chk("drained_vld", out_valid, 0);

    // Steady stream: pointers wrap twice.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 64'h100 + 64'(4 * k), 3'd0, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("stream_pc", out_pc, 64'h100 + 64'(4 * k));
      tick();
      chk("stream_count", count, 0);
`else
      if (k > 0) chk("stream_pc", out_pc, 64'h100 + 64'(4 * (k - 1)));
      tick();
      chk("stream_count", count, 1);
`endif
    end
    drive(1'b0, 64'h0, 3'd0, 1'b1);
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("stream_last_pc", out_pc, 64'h124);
    tick();
`endif
    chk("stream_end_count", count, 0);

    // Poison: good entry, faulting entry, then held request must be refused.
    drive(1'b1, 64'h200, 3'd0, 1'b0);
    tick();
    drive(1'b1, 64'h8000_0002, INSTR_MISALIGN, 1'b0);
    tick();
    drive(1'b1, 64'h300, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("poison_in_ready", in_ready, 0);
      tick();
    end
    chk("poison_count", count, 2);
    drive(1'b1, 64'h300, 3'd0, 1'b1);
    chk("poison_pc0", out_pc, 64'h200);
    chk("poison_err0", out_error, 0);
    tick();
    chk("poison_pc1", out_pc, 64'h8000_0002);
    chk("poison_err1", out_error, 64'(INSTR_MISALIGN));
    tick();
    chk("poison_empty_vld", out_valid, 0);
    chk("poison_still", in_ready, 0);
    chk("poison_count0", count, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 3'd0, 1'b0);
    chk("unpoison_in_ready", in_ready, 1);
    chk("unpoison_count", count, 0);

    // Flush with count=3 and simultaneous enq/deq requests.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h400 + 64'(4 * i), 3'd0, 1'b0);
      tick();
    end
    chk("pre_flush_count", count, 3);
    flush = 1'b1;
    drive(1'b1, 64'h4F0, 3'd0, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 3'd0, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_vld", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    drive(1'b1, 64'h500, 3'd0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 3'd0, 1'b0);
    chk("post_flush_pc", out_pc, 64'h500);
    chk("post_flush_count", count, 1);

    // Reset mid-operation.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_vld", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);

    // Empty queue, consumer ready: bypass vs one-cycle latency.
    drive(1'b1, 64'h8000_1000, 3'd0, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_vld", out_valid, 1);
    chk("byp_pc", out_pc, 64'h8000_1000);
    tick();
    drive(1'b0, 64'h0, 3'd0, 1'b1);
    chk("byp_count", count, 0);
    chk("byp_after_vld", out_valid, 0);
`else
    chk("nobyp_vld", out_valid, 0);
    tick();
    drive(1'b0, 64'h0, 3'd0, 1'b1);
    chk("nobyp_vld1", out_valid, 1);
    chk("nobyp_pc", out_pc, 64'h8000_1000);
    chk("nobyp_count", count, 1);
    tick();
    chk("nobyp_drained", count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
